fusion_mac_unit: RTL and testbench

Parametrised, pipelined bit-fusion multiply-accumulate element. It supersedes the single-cycle fusion unit with four additions: generic operand width, signed arithmetic, multi-beat accumulation with saturation, and valid/ready flow control. Each beat splits the operand words into precision-selected sub-elements, forms per-lane dot products, and accumulates them across beats. It sits in the systolic column, taking a partial sum from the unit above and forwarding a packed per-lane result below.

---
 rtl/fusion_mac_unit.sv | 212 +++++++++++++++++++++
 tb/tb_fusion_mac_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_mac_unit.sv
// Pipelined bit-fusion MAC element: splits operand words into precision-selected
// sub-elements, forms per-lane dot products and accumulates them with saturation.
module fusion_mac_unit #(
    parameter int MAX_W = 8,
    parameter int ACC_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MAX_W-1:0]           in,
    input  logic [MAX_W-1:0]           weight,
    input  logic [1:0]                 in_wsel,
    input  logic [1:0]                 wt_wsel,
    input  logic                       s_in,
    input  logic                       s_weight,
    input  logic                       first,
    input  logic                       last,
    input  logic [MAX_W/2*ACC_W-1:0]   psum_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MAX_W/2*ACC_W-1:0]   psum_out,
    output logic                       sat,
    output logic                       cfg_err
);

    localparam int L  = MAX_W / 2;
    localparam int SW = MAX_W + 2;
    localparam int PW = 2 * MAX_W + 3;
    localparam int EW = ((ACC_W > PW) ? ACC_W : PW) + 2;
    localparam logic signed [EW-1:0] SMAX = (EW'(1) <<< (ACC_W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] SMIN = -(EW'(1) <<< (ACC_W - 1));
    localparam logic signed [EW-1:0] UMAX = (EW'(1) <<< ACC_W) - EW'(1);

    // The 16b code only exists when the word is 16 bits wide; otherwise fall back to 2b.
    function automatic logic [1:0] dec_w(input logic [1:0] code);
        return (MAX_W == 8 && code == 2'd3) ? 2'd0 : code;
    endfunction

    function automatic int wbits(input logic [1:0] code);
        return 2 << code;
    endfunction

    function automatic int n_elem(input logic [1:0] code);
        return MAX_W >> (int'(code) + 1);
    endfunction

    function automatic logic signed [MAX_W:0] elem(input logic [MAX_W-1:0] word,
                                                   input int idx, input int w,
                                                   input logic sgn);
        logic [MAX_W-1:0] t;
        logic [MAX_W:0]   e;
        t = (word >> (idx * w)) << (MAX_W - w);
        e = {sgn & t[MAX_W-1], t};
        return $signed(e) >>> (MAX_W - w);
    endfunction

    logic [1:0]          cfg_iw_q, cfg_iw_d, cfg_ww_q, cfg_ww_d;
    logic                cfg_si_q, cfg_si_d, cfg_sw_q, cfg_sw_d;
    logic                cfg_err_q, cfg_err_d;
    logic                s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
    logic                s1_last_q, s1_last_d, s1_sgn_q, s1_sgn_d;
    logic [L-1:0]        s1_act_q, s1_act_d;
    logic [L*PW-1:0]     s1_p_q, s1_p_d;
    logic [L*ACC_W-1:0]  s1_psum_q, s1_psum_d;
    logic [L*ACC_W-1:0]  acc_q, acc_d, acc_nxt;
    logic                sat_acc_q, sat_acc_d, sat_run;
    logic                out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic [L*ACC_W-1:0]  out_psum_q, out_psum_d;

    logic en, accept, cfg_load;

    // Handshake: a beat transfers on a rising edge with in_valid & in_ready; a result
    // transfers with out_valid & out_ready. in_ready is low only while a result is held.
    assign en       = ~out_valid_q | out_ready;
    assign accept   = in_valid & en;
    assign cfg_load = accept & first;

    always_comb begin : front_end
        logic [1:0]            eff_iw, eff_ww;
        logic                  eff_si, eff_sw;
        logic signed [SW-1:0]  xsum;
        int                    iwb, wwb;
        eff_iw = cfg_load ? dec_w(in_wsel) : cfg_iw_q;
        eff_ww = cfg_load ? dec_w(wt_wsel) : cfg_ww_q;
        eff_si = cfg_load ? s_in : cfg_si_q;
        eff_sw = cfg_load ? s_weight : cfg_sw_q;
        cfg_iw_d  = eff_iw;
        cfg_ww_d  = eff_ww;
        cfg_si_d  = eff_si;
        cfg_sw_d  = eff_sw;
        cfg_err_d = cfg_err_q |
                    (cfg_load & (MAX_W == 8) & ((in_wsel == 2'd3) | (wt_wsel == 2'd3)));
        iwb  = wbits(eff_iw);
        wwb  = wbits(eff_ww);
        xsum = '0;
        for (int i = 0; i < L; i++) begin
            if (i < n_elem(eff_iw)) xsum = xsum + SW'(elem(in, i, iwb, eff_si));
        end
        s1_p_d   = '0;
        s1_act_d = '0;
        for (int j = 0; j < L; j++) begin
            if (j < n_elem(eff_ww)) begin
                s1_p_d[j*PW +: PW] = PW'(elem(weight, j, wwb, eff_sw)) * PW'(xsum);
                s1_act_d[j]        = 1'b1;
            end
        end
        if (!en) begin
            s1_p_d   = s1_p_q;
            s1_act_d = s1_act_q;
        end
        s1_valid_d = en ? in_valid : s1_valid_q;
        s1_first_d = en ? first : s1_first_q;
        s1_last_d  = en ? last : s1_last_q;
        s1_sgn_d   = en ? (eff_si | eff_sw) : s1_sgn_q;
        s1_psum_d  = en ? psum_in : s1_psum_q;
    end

    always_comb begin : accumulate
        logic [ACC_W-1:0]      base;
        logic signed [EW-1:0]  base_ext, sum_ext, lim;
        logic                  any_clamp;
        any_clamp = 1'b0;
        acc_nxt   = '0;
        base      = '0;
        base_ext  = '0;
        sum_ext   = '0;
        lim       = '0;
        for (int j = 0; j < L; j++) begin
            base     = s1_first_q ? s1_psum_q[j*ACC_W +: ACC_W] : acc_q[j*ACC_W +: ACC_W];
            base_ext = s1_sgn_q ? EW'(signed'(base)) : EW'(base);
            sum_ext  = base_ext + EW'(signed'(s1_p_q[j*PW +: PW]));
            lim      = sum_ext;
            if (s1_sgn_q) begin
                if (sum_ext > SMAX)      lim = SMAX;
                else if (sum_ext < SMIN) lim = SMIN;
            end else begin
                if (sum_ext[EW-1])       lim = '0;
                else if (sum_ext > UMAX) lim = UMAX;
            end
            if (s1_act_q[j]) begin
                acc_nxt[j*ACC_W +: ACC_W] = ACC_W'(lim);
                any_clamp = any_clamp | (lim != sum_ext);
            end
        end
        sat_run     = (s1_first_q ? 1'b0 : sat_acc_q) | any_clamp;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        out_valid_d = out_valid_q;
        out_psum_d  = out_psum_q;
        out_sat_d   = out_sat_q;
        if (en) begin
            out_valid_d = s1_valid_q & s1_last_q;
            if (s1_valid_q && s1_last_q) begin
                out_psum_d = acc_nxt;
                out_sat_d  = sat_run;
                acc_d      = '0;
                sat_acc_d  = 1'b0;
            end else if (s1_valid_q) begin
                acc_d      = acc_nxt;
                sat_acc_d  = sat_run;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_iw_q    <= '0;
            cfg_ww_q    <= '0;
            cfg_si_q    <= 1'b0;
            cfg_sw_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_act_q    <= '0;
            s1_p_q      <= '0;
            s1_psum_q   <= '0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cfg_iw_q    <= cfg_iw_d;
            cfg_ww_q    <= cfg_ww_d;
            cfg_si_q    <= cfg_si_d;
            cfg_sw_q    <= cfg_sw_d;
            cfg_err_q   <= cfg_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_sgn_q    <= s1_sgn_d;
            s1_act_q    <= s1_act_d;
            s1_p_q      <= s1_p_d;
            s1_psum_q   <= s1_psum_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            out_valid_q <= out_valid_d;
            out_psum_q  <= out_psum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign psum_out  = out_psum_q;
    assign sat       = out_sat_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fusion_mac_unit.sv
// Bench for fusion_mac_unit: directed literal cases plus randomized traffic checked
// against an arithmetic model of the accumulation rules.
module tb_fusion_mac_unit;
  localparam int MAX_W = 8;
  localparam int ACC_W = 16;
  localparam int L = MAX_W / 2;
  localparam int PV = L * ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [MAX_W-1:0] in = '0;
  logic [MAX_W-1:0] weight = '0;
  logic [1:0] in_wsel = '0;
  logic [1:0] wt_wsel = '0;
  logic s_in = 1'b0;
  logic s_weight = 1'b0;
  logic first = 1'b0;
  logic last = 1'b0;
  logic [PV-1:0] psum_in = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [PV-1:0] psum_out;
  logic sat;
  logic cfg_err;

  fusion_mac_unit #(.MAX_W(MAX_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .weight(weight), .in_wsel(in_wsel), .wt_wsel(wt_wsel),
    .s_in(s_in), .s_weight(s_weight), .first(first), .last(last),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
    .psum_out(psum_out), .sat(sat), .cfg_err(cfg_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [PV:0] exp_q[$];

  task automatic check(input string name, input logic [PV:0] act, input logic [PV:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int m_iw = 2, m_ww = 2;
  bit m_si = 0, m_sw = 0, m_err = 0, m_sat = 0;
  longint m_acc[L];

  function automatic longint elem_val(input logic [MAX_W-1:0] word, input int idx,
                                      input int w, input bit sgn);
    longint v;
    v = longint'(word >> (idx * w)) & ((longint'(1) << w) - 1);
    if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_iw = 2; m_ww = 2; m_si = 0; m_sw = 0; m_err = 0; m_sat = 0;
    for (int j = 0; j < L; j++) m_acc[j] = 0;
  endtask

  task automatic model_beat();
    longint sx, base, v, lo, hi;
    bit clamp, sgn;
    logic [PV-1:0] res;
    logic [ACC_W-1:0] pl;
    if (first) begin
      m_iw = (in_wsel == 2'd3) ? 2 : (2 << in_wsel);
      m_ww = (wt_wsel == 2'd3) ? 2 : (2 << wt_wsel);
      if (in_wsel == 2'd3 || wt_wsel == 2'd3) m_err = 1;
      m_si = s_in;
      m_sw = s_weight;
    end
    sgn = m_si | m_sw;
    lo = sgn ? -(longint'(1) << (ACC_W - 1)) : 0;
    hi = sgn ? (longint'(1) << (ACC_W - 1)) - 1 : (longint'(1) << ACC_W) - 1;
    sx = 0;
    for (int i = 0; i < MAX_W / m_iw; i++) sx += elem_val(in, i, m_iw, m_si);
    clamp = 0;
    res = '0;
    for (int j = 0; j < L; j++) begin
      if (j < MAX_W / m_ww) begin
        pl = psum_in[j*ACC_W +: ACC_W];
        if (first) base = sgn ? longint'($signed(pl)) : longint'(pl);
        else base = m_acc[j];
        v = base + elem_val(weight, j, m_ww, m_sw) * sx;
        if (v > hi) begin v = hi; clamp = 1; end
        else if (v < lo) begin v = lo; clamp = 1; end
        m_acc[j] = v;
        res[j*ACC_W +: ACC_W] = ACC_W'(v);
      end else begin
        m_acc[j] = 0;
      end
    end
    m_sat = (first ? 1'b0 : m_sat) | clamp;
    if (last) begin
      exp_q.push_back({m_sat, res});
      for (int j = 0; j < L; j++) m_acc[j] = 0;
      m_sat = 0;
    end
  endtask

  // Compare process: every cycle out of reset, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      check("cfg_err", (PV+1)'(cfg_err), (PV+1)'(m_err));
      check("in_ready", (PV+1)'(in_ready), (PV+1)'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL result: out_valid with psum %h, required no result", psum_out);
        end else begin
          check("result", {sat, psum_out}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_beat();
    end
  end

  // ---------------- driver tasks ----------------
  bit rnd_bp = 0;
  always @(posedge clk) begin
    #2;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic [1:0] iws,
                      input logic [1:0] wws, input bit si, input bit sw, input bit f,
                      input bit l, input logic [PV-1:0] ps);
    int t;
    in = a; weight = w; in_wsel = iws; wt_wsel = wws; s_in = si; s_weight = sw;
    first = f; last = l; psum_in = ps; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin t++; @(negedge clk); end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready 0 for 100 cycles, required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 50);
    if (!out_valid) begin
      n_checks++;
      $display("FAIL out_timeout: out_valid 0 after 50 cycles, required 1");
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, (PV+1)'(out_valid), '0);
    check({tag, "_in_ready"}, (PV+1)'(in_ready), (PV+1)'(1));
    check({tag, "_psum_sat"}, {sat, psum_out}, '0);
    check({tag, "_cfg_err"}, (PV+1)'(cfg_err), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [PV-1:0] ps;
    bit f, l;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8x8 unsigned single beat; inactive lanes must read 0 despite nonzero psum_in
    send(8'd200, 8'd100, 2'd2, 2'd2, 0, 0, 1, 1, {16'd7, 16'd7, 16'd7, 16'd5});
    in_valid = 1'b0;
    wait_out(cyc);
    check("t1_latency", (PV+1)'(cyc), (PV+1)'(2));
    check("t1_result", {sat, psum_out}, {1'b0, 16'd0, 16'd0, 16'd0, 16'd20005});
    @(posedge clk); #1;

    // 2x2 unsigned
    send(8'hFF, 8'hE4, 2'd0, 2'd0, 0, 0, 1, 1, '0);
    in_valid = 1'b0;
    wait_out(cyc);
    check("t2_result", {sat, psum_out}, {1'b0, 16'd36, 16'd24, 16'd12, 16'd0});
    @(posedge clk); #1;

    // 4x4 signed
    send(8'h2F, 8'h9F, 2'd1, 2'd1, 1, 1, 1, 1, '0);
    in_valid = 1'b0;
    wait_out(cyc);
    check("t3_result", {sat, psum_out}, {1'b0, 16'h0, 16'h0, 16'hFFF9, 16'hFFFF});
    @(posedge clk); #1;

    // three-beat saturating accumulation; later beats carry mode bits that must be ignored
    send(8'd255, 8'd255, 2'd2, 2'd2, 0, 0, 1, 0, '0);
    send(8'd255, 8'd255, 2'd0, 2'd0, 1, 0, 0, 0, '0);
    send(8'd255, 8'd255, 2'd0, 2'd0, 1, 0, 0, 1, '0);
    in_valid = 1'b0;
    wait_out(cyc);
    check("t4_sat_result", {sat, psum_out}, {1'b1, 48'h0, 16'hFFFF});
    @(posedge clk); #1;
    send(8'd200, 8'd100, 2'd2, 2'd2, 0, 0, 1, 1, {48'h0, 16'd5});
    in_valid = 1'b0;
    wait_out(cyc);
    check("t4_next_clean", {sat, psum_out}, {1'b0, 48'h0, 16'd20005});
    @(posedge clk); #1;

    // backpressure: A shown and held, B waits in the first stage
    out_ready = 1'b0;
    send(8'd3, 8'd4, 2'd2, 2'd2, 0, 0, 1, 1, '0);
    send(8'd5, 8'd6, 2'd2, 2'd2, 0, 0, 1, 1, '0);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", (PV+1)'(in_ready), '0);
      check("bp_held", {out_valid, psum_out}, {1'b1, 48'h0, 16'd12});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_replace", {out_valid, psum_out}, {1'b1, 48'h0, 16'd30});
    @(posedge clk); #1;

    // randomized traffic with random output backpressure
    rnd_bp = 1;
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      f = (k == 0) || ($urandom_range(0, 3) == 0);
      l = (k == 399) || ($urandom_range(0, 2) == 0);
      ps = {$urandom, $urandom};
      send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), f, l, ps);
    end
    in_valid = 1'b0;
    rnd_bp = 0;
    @(posedge clk); #3;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin @(posedge clk); cyc++; end
    @(negedge clk);
    check("drain_empty", (PV+1)'(exp_q.size()), '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // illegal input width decodes as 2b and raises the sticky error
    send(8'hFF, 8'hE4, 2'd3, 2'd0, 0, 0, 1, 1, '0);
    in_valid = 1'b0;
    wait_out(cyc);
    check("illegal_result", {sat, psum_out}, {1'b0, 16'd36, 16'd24, 16'd12, 16'd0});
    check("illegal_cfg_err", (PV+1)'(cfg_err), (PV+1)'(1));
    @(posedge clk); #1;

    // reset in the middle of an accumulation
    send(8'd9, 8'd9, 2'd2, 2'd2, 0, 0, 1, 0, '0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd200, 8'd100, 2'd2, 2'd2, 0, 0, 1, 1, {48'h0, 16'd5});
    in_valid = 1'b0;
    wait_out(cyc);
    check("post_rst_result", {sat, psum_out}, {1'b0, 48'h0, 16'd20005});
    check("post_rst_cfg_err", (PV+1)'(cfg_err), '0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
